// File: rtl/fp_issue.sv
// Request-side sequencer for the FP execute stage: accepts one op, issues it,
// waits for completion (with watchdog), returns the response, and keeps sticky fflags.
package fp_issue_pkg;
  typedef struct packed {
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fmadd;
    logic fsgnj;
    logic fcmp;
  } fp_operation_type;
endpackage

module fp_issue
  import fp_issue_pkg::*;
#(
  parameter int TAGW    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_data1,
  input  logic [63:0]      req_data2,
  input  logic [63:0]      req_data3,
  input  fp_operation_type req_op,
  input  logic [1:0]       req_fmt,
  input  logic [2:0]       req_rm,
  input  logic [TAGW-1:0]  req_tag,
  input  logic [2:0]       frm,
  output logic             exe_enable,
  output logic [63:0]      exe_data1,
  output logic [63:0]      exe_data2,
  output logic [63:0]      exe_data3,
  output fp_operation_type exe_op,
  output logic [1:0]       exe_fmt,
  output logic [2:0]       exe_rm,
  input  logic [63:0]      exe_result,
  input  logic [4:0]       exe_flags,
  input  logic             exe_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_err,
  output logic [4:0]       fflags,
  input  logic             fflags_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [63:0]      d1_r, d2_r, d3_r;
  fp_operation_type op_r;
  logic [1:0]       fmt_r;
  logic [2:0]       rm_r;
  logic [TAGW-1:0]  tag_r;

  logic       accept, busy, capture, tmo, rm_bad;
  logic [2:0] rm_res;

  assign accept  = req_valid && req_ready;
  assign rm_res  = (req_rm == 3'b111) ? frm : req_rm;
  assign rm_bad  = (rm_res >= 3'd5);
  assign busy    = (state == EXEC) || (state == WAIT);
  // A late exe_ready on the last watchdog cycle still counts as completion.
  assign capture = busy && exe_ready;
  assign tmo     = (state == WAIT) && !exe_ready && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = rm_bad ? RESP : EXEC;
      EXEC: state_nxt = exe_ready ? RESP : WAIT;
      WAIT: if (exe_ready || tmo) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign exe_enable = (state == EXEC);
  assign exe_op     = busy ? op_r : '0;
  assign exe_data1  = d1_r;
  assign exe_data2  = d2_r;
  assign exe_data3  = d3_r;
  assign exe_fmt    = fmt_r;
  assign exe_rm     = rm_r;
  assign rsp_tag    = tag_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      d1_r       <= '0;
      d2_r       <= '0;
      d3_r       <= '0;
      op_r       <= '0;
      fmt_r      <= '0;
      rm_r       <= '0;
      tag_r      <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      fflags     <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        d1_r  <= req_data1;
        d2_r  <= req_data2;
        d3_r  <= req_data3;
        op_r  <= req_op;
        fmt_r <= req_fmt;
        rm_r  <= rm_res;
        tag_r <= req_tag;
        if (rm_bad) begin
          rsp_result <= '0;
          rsp_flags  <= '0;
          rsp_err    <= 1'b1;
        end
      end

      if (state == EXEC)      cnt <= CW'(1);
      else if (state == WAIT) cnt <= cnt + CW'(1);

      if (capture) begin
        rsp_result <= exe_result;
        rsp_flags  <= exe_flags;
        rsp_err    <= 1'b0;
      end else if (tmo) begin
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_err    <= 1'b1;
      end

      // Error responses never reach the sticky flags.
      if (capture)         fflags <= (fflags_clr ? 5'b0 : fflags) | exe_flags;
      else if (fflags_clr) fflags <= '0;
    end
  end

endmodule
